comet2_fetch_unit: RTL
======================

Name: comet2_fetch_unit

Overview:
- Instruction fetch stage of the COMET II CPU; sits directly upstream of the CPU memory read port and feeds the instruction decoder.
- Drives the RAM read port (re/raddr, combinational rdata) and fetches one or two words per instruction, depending on the opcode.
- Presents complete instructions to the decoder with a valid/ready handshake.
- Yields the RAM port to execute-stage loads and stores, and takes branch redirects.

Parameters:
- RESET_PC, 16'h0000, program counter value after reset.

Ports:
- mclk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- mem_busy  input  1  execute stage owns the RAM port this cycle; fetch must not read.
- mem_re  output  1  RAM read enable.
- mem_raddr  output  16  RAM read address.
- mem_rdata  input  16  RAM read data, valid in the same cycle as mem_re.
- jmp_valid  input  1  redirect request (JUMP/CALL/RET taken).
- jmp_addr  input  16  redirect target.
- ir_valid  output  1  instruction available.
- ir_ready  input  1  decoder accepts the instruction.
- ir_word1  output  16  opcode word.
- ir_word2  output  16  address word; 16'h0000 for one-word instructions.
- ir_two_word  output  1  1 for a two-word instruction.
- ir_pc  output  16  address of ir_word1.

Behaviour:
- Reset values (while rst_n=0, asynchronous):
  - pc=RESET_PC, state=FETCH1.
  - ir_valid=0, ir_word1=0, ir_word2=0, ir_two_word=0, ir_pc=0.
- States: FETCH1, FETCH2, HOLD.
- Memory read port:
  - mem_raddr = pc (combinational).
  - mem_re = (state==FETCH1 or FETCH2) && !mem_busy && !jmp_valid.
- Two-word opcode set (mem_rdata[15:8]): 10,11,12,20,21,22,23,30,31,32,40,41,50,51,52,53,61,62,63,64,65,66,70,80,F0. All other opcodes are one-word (e.g. 00, 14, 24-27, 34-36, 44, 45, 71, 81).
- FETCH1:
  - If mem_re=1: ir_word1<=mem_rdata, ir_pc<=pc, pc<=pc+1.
  - Two-word opcode: ir_two_word<=1, go to FETCH2.
  - One-word opcode: ir_two_word<=0, ir_word2<=0, ir_valid<=1, go to HOLD.
  - If mem_re=0: hold all state.
- FETCH2:
  - If mem_re=1: ir_word2<=mem_rdata, pc<=pc+1, ir_valid<=1, go to HOLD.
  - Otherwise hold all state.
- HOLD:
  - ir_* outputs stable while ir_valid=1 and ir_ready=0.
  - On ir_ready=1: ir_valid<=0, go to FETCH1.
- Latency: with no stalls, ir_valid rises 1 cycle after entering FETCH1 for a one-word instruction, 2 cycles for a two-word instruction. Throughput is one instruction per 2 cycles (one-word) or per 3 cycles (two-word); there is no prefetch.
- pc arithmetic is 16-bit modulo: FFFF+1=0000. A two-word instruction at FFFF takes its word2 from 0000.
- Redirect: jmp_valid has priority over every other event.
  - Next state: pc<=jmp_addr, state<=FETCH1, ir_valid<=0.
  - Any partially fetched instruction is discarded.
  - If jmp_valid coincides with ir_valid&&ir_ready, the handshake counts as complete (instruction consumed) and the redirect still applies.
- mem_busy and jmp_valid together: the redirect applies, no read is issued.
- Reset asserted mid-fetch: immediate return to reset values; the first read after release is at RESET_PC.

Test Plan:
- Reset release, RAM[0000]=1210, RAM[0001]=0003, ir_ready=1: mem_raddr 0000 then 0001 on consecutive cycles; then ir_valid=1 with ir_word1=1210, ir_word2=0003, ir_two_word=1, ir_pc=0000; next read at 0002.
- One-word: pc=0016, RAM[0016]=1443, RAM[0017]=1404: two instructions presented, each with ir_two_word=0 and ir_word2=0000, ir_pc=0016 then 0017, one cycle fetch each.
- mem_busy=1 for 3 cycles during FETCH2 of 1100/0040: mem_re=0 for those cycles; word2=0040 is captured on the first free cycle; pc not advanced during the stall.
- ir_ready=0 for 5 cycles: ir_valid and ir_* stable, mem_re=0; on ir_ready=1 the next fetch starts at the following address.
- jmp_valid with jmp_addr=003B asserted during FETCH2: partial instruction dropped, ir_valid never asserted for it, next mem_raddr=003B; then RAM[003B]=8000 followed by 0030 is delivered.
- pc=FFFF, RAM[FFFF]=1200, RAM[0000]=00AA: ir_word1=1200, ir_word2=00AA, ir_pc=FFFF; next fetch at 0001. Then assert rst_n=0 mid-FETCH2: outputs reset immediately and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/comet2_fetch_unit.sv
// COMET II instruction fetch stage.
// Reads one or two words per instruction from the CPU RAM read port,
// depending on the opcode. It then presents the complete instruction to the
// decoder. The RAM port is given up whenever the execute stage claims it
// (mem_busy). A taken branch (jmp_valid) redirects fetch and discards any
// partially fetched instruction.
//
// Decoder handshake (valid/ready):
//   ir_valid is raised only when a complete instruction sits in ir_*. While
//   ir_valid=1 and ir_ready=0, every ir_* output holds its value. The transfer
//   happens on a rising mclk edge where ir_valid=1 and ir_ready=1. ir_valid
//   never drops without a transfer, except on a redirect or a reset.
//   If a redirect coincides with a transfer, the instruction counts as
//   consumed.
module comet2_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        mem_busy,
    output logic        mem_re,
    output logic [15:0] mem_raddr,
    input  logic [15:0] mem_rdata,
    input  logic        jmp_valid,
    input  logic [15:0] jmp_addr,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [15:0] ir_word1,
    output logic [15:0] ir_word2,
    output logic        ir_two_word,
    output logic [15:0] ir_pc,
    output logic [1:0]  dbg_state
);

    // FETCH1: reading the opcode word; FETCH2: reading the address word;
    // HOLD: complete instruction waiting for the decoder.
    localparam logic [1:0] FETCH1 = 2'd0;
    localparam logic [1:0] FETCH2 = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    logic [1:0]  state;
    logic [15:0] pc;

    logic [1:0]  state_nxt;
    logic [15:0] pc_nxt;
    logic        ir_valid_nxt;
    logic [15:0] ir_word1_nxt;
    logic [15:0] ir_word2_nxt;
    logic        ir_two_word_nxt;
    logic [15:0] ir_pc_nxt;

    logic        fetch_phase;
    logic        op_two_word;
    logic [15:0] pc_inc;

    // Opcodes that carry an address word after the opcode word.
    function automatic logic is_two_word(input logic [7:0] op);
        case (op)
            8'h10, 8'h11, 8'h12,
            8'h20, 8'h21, 8'h22, 8'h23,
            8'h30, 8'h31, 8'h32,
            8'h40, 8'h41,
            8'h50, 8'h51, 8'h52, 8'h53,
            8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66,
            8'h70, 8'h80, 8'hF0:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    // The read port is used only while fetching, and only when neither the
    // execute stage nor a redirect needs this cycle.
    always_comb begin
        fetch_phase = (state == FETCH1) || (state == FETCH2);
        mem_re      = fetch_phase && !mem_busy && !jmp_valid;
        mem_raddr   = pc;
        op_two_word = is_two_word(mem_rdata[15:8]);
        pc_inc      = pc + 16'd1;
        dbg_state   = state;
    end

    // Next-state logic: a redirect wins over everything else. Otherwise the
    // FSM advances only on a real read or a decoder transfer.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        ir_valid_nxt    = ir_valid;
        ir_word1_nxt    = ir_word1;
        ir_word2_nxt    = ir_word2;
        ir_two_word_nxt = ir_two_word;
        ir_pc_nxt       = ir_pc;

        if (jmp_valid) begin
            pc_nxt       = jmp_addr;
            state_nxt    = FETCH1;
            ir_valid_nxt = 1'b0;
        end else begin
            case (state)
                FETCH1: begin
                    if (mem_re) begin
                        ir_word1_nxt = mem_rdata;
                        ir_pc_nxt    = pc;
                        pc_nxt       = pc_inc;
                        if (op_two_word) begin
                            ir_two_word_nxt = 1'b1;
                            state_nxt       = FETCH2;
                        end else begin
                            ir_two_word_nxt = 1'b0;
                            ir_word2_nxt    = 16'h0000;
                            ir_valid_nxt    = 1'b1;
                            state_nxt       = HOLD;
                        end
                    end
                end
                FETCH2: begin
                    if (mem_re) begin
                        ir_word2_nxt = mem_rdata;
                        pc_nxt       = pc_inc;
                        ir_valid_nxt = 1'b1;
                        state_nxt    = HOLD;
                    end
                end
                HOLD: begin
                    if (ir_ready) begin
                        ir_valid_nxt = 1'b0;
                        state_nxt    = FETCH1;
                    end
                end
                default: begin
                    // Unused encoding: recover by restarting fetch at pc.
                    ir_valid_nxt = 1'b0;
                    state_nxt    = FETCH1;
                end
            endcase
        end
    end

    // State and instruction register update, asynchronous active-low reset.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH1;
            pc          <= RESET_PC;
            ir_valid    <= 1'b0;
            ir_word1    <= 16'h0000;
            ir_word2    <= 16'h0000;
            ir_two_word <= 1'b0;
            ir_pc       <= 16'h0000;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            ir_valid    <= ir_valid_nxt;
            ir_word1    <= ir_word1_nxt;
            ir_word2    <= ir_word2_nxt;
            ir_two_word <= ir_two_word_nxt;
            ir_pc       <= ir_pc_nxt;
        end
    end

endmodule
